// File: rtl/exec_stage_pipe.sv
// exec_stage_pipe: EX stage of the pipelined core.
//   ALU with operand-B select, destination-register select, an iterative
//   shift-add multiplier, backpressure and flush, feeding a registered
//   EX/MEM output with a valid/ready handshake.
// Ports:
//   clk, rst_n (synchronous, active low), flush
//   in_valid/in_ready   : ID/EX handshake
//   regWriteD, memToRegD, memWriteD, aluControlD, aluSrcD, regDstD,
//   signImmD ([10:6] = shamt), rsD/rtD/rdD, value1 (A), value2 (reg B)
//   out_valid/out_ready : EX/MEM handshake
//   regWriteE, memToRegE, memWriteE, writeRegE, aluOutE, writeDataE
// Optional feature macro EXEC_OVF_TRAP_EN: adds ovfE (signed ADD/SUB
//   overflow flag); a flagged op has regWriteE forced to 0.
module exec_stage_pipe #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned CTRL_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               regWriteD,
    input  logic               memToRegD,
    input  logic               memWriteD,
    input  logic [CTRL_W-1:0]  aluControlD,
    input  logic               aluSrcD,
    input  logic               regDstD,
    input  logic [DATA_W-1:0]  signImmD,
    input  logic [RADDR_W-1:0] rsD,
    input  logic [RADDR_W-1:0] rtD,
    input  logic [RADDR_W-1:0] rdD,
    input  logic [DATA_W-1:0]  value1,
    input  logic [DATA_W-1:0]  value2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               regWriteE,
    output logic               memToRegE,
    output logic               memWriteE,
    output logic [RADDR_W-1:0] writeRegE,
    output logic [DATA_W-1:0]  aluOutE,
    output logic [DATA_W-1:0]  writeDataE
`ifdef EXEC_OVF_TRAP_EN
    ,
    output logic               ovfE
`endif
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    localparam logic [CTRL_W-1:0] OP_AND = CTRL_W'(4'b0000);
    localparam logic [CTRL_W-1:0] OP_OR  = CTRL_W'(4'b0001);
    localparam logic [CTRL_W-1:0] OP_ADD = CTRL_W'(4'b0010);
    localparam logic [CTRL_W-1:0] OP_XOR = CTRL_W'(4'b0011);
    localparam logic [CTRL_W-1:0] OP_SLL = CTRL_W'(4'b0100);
    localparam logic [CTRL_W-1:0] OP_SRL = CTRL_W'(4'b0101);
    localparam logic [CTRL_W-1:0] OP_SUB = CTRL_W'(4'b0110);
    localparam logic [CTRL_W-1:0] OP_SLT = CTRL_W'(4'b0111);
    localparam logic [CTRL_W-1:0] OP_SRA = CTRL_W'(4'b1000);
    localparam logic [CTRL_W-1:0] OP_NOR = CTRL_W'(4'b1100);
    localparam logic [CTRL_W-1:0] OP_MUL = CTRL_W'(4'b1111);

    typedef enum logic [0:0] {S_IDLE, S_MUL} state_t;

    state_t state, state_next;

    logic [DATA_W-1:0]  op_b;
    logic [RADDR_W-1:0] write_reg;
    logic [CNT_W-1:0]   sh_amt;
    logic [DATA_W-1:0]  alu_res;
    logic               alu_ovf;
    logic               is_mul;
    logic               accept;
    logic               out_free;
    logic               load_single;
    logic               load_mul;
    logic               mul_start;

    logic [DATA_W-1:0]  mul_acc;
    logic [DATA_W-1:0]  mul_mcand;
    logic [DATA_W-1:0]  mul_mplier;
    logic [DATA_W-1:0]  mul_sum;
    logic [CNT_W-1:0]   mul_cnt;
    logic               mul_last;
    logic               mul_rw;
    logic               mul_m2r;
    logic               mul_mw;
    logic [RADDR_W-1:0] mul_wreg;
    logic [DATA_W-1:0]  mul_wdata;

    // rs is carried by the decode bundle but not needed in EX
    logic unused_rs;
    assign unused_rs = ^rsD;

    // Operand / destination select and handshake
    assign op_b      = aluSrcD ? signImmD : value2;
    assign write_reg = regDstD ? rdD : rtD;
    assign sh_amt    = CNT_W'(8'(signImmD[10:6]) % 8'(DATA_W));
    assign is_mul    = (aluControlD == OP_MUL);
    assign out_free  = !out_valid || out_ready;
    assign in_ready  = rst_n && (state == S_IDLE) && out_free && !flush;
    assign accept    = in_valid && in_ready;

    // Multiplier step: add the shifted multiplicand when the current multiplier bit is set
    assign mul_last = (mul_cnt == CNT_W'(DATA_W - 1));
    assign mul_sum  = mul_acc + (mul_mplier[0] ? mul_mcand : '0);

    // Single-cycle ALU
    always_comb begin
        alu_res = '0;
        unique case (aluControlD)
            OP_AND:  alu_res = value1 & op_b;
            OP_OR:   alu_res = value1 | op_b;
            OP_ADD:  alu_res = value1 + op_b;
            OP_XOR:  alu_res = value1 ^ op_b;
            OP_SLL:  alu_res = value1 << sh_amt;
            OP_SRL:  alu_res = value1 >> sh_amt;
            OP_SRA:  alu_res = DATA_W'($signed(value1) >>> sh_amt);
            OP_SUB:  alu_res = value1 - op_b;
            OP_SLT:  alu_res = DATA_W'($signed(value1) < $signed(op_b));
            OP_NOR:  alu_res = ~(value1 | op_b);
            default: alu_res = '0;
        endcase
    end

`ifdef EXEC_OVF_TRAP_EN
    // Signed overflow: result sign disagrees with the sign the operands imply
    always_comb begin
        alu_ovf = 1'b0;
        if (aluControlD == OP_ADD)
            alu_ovf = (value1[DATA_W-1] == op_b[DATA_W-1]) &&
                      (alu_res[DATA_W-1] != value1[DATA_W-1]);
        else if (aluControlD == OP_SUB)
            alu_ovf = (value1[DATA_W-1] != op_b[DATA_W-1]) &&
                      (alu_res[DATA_W-1] != value1[DATA_W-1]);
    end
`else
    assign alu_ovf = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next state and load strobes
    always_comb begin
        state_next  = state;
        load_single = 1'b0;
        load_mul    = 1'b0;
        mul_start   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    if (is_mul) begin
                        mul_start  = 1'b1;
                        state_next = S_MUL;
                    end else begin
                        load_single = 1'b1;
                    end
                end
            end
            S_MUL: begin
                if (mul_last && out_free) begin
                    load_mul   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (flush) begin
            state_next  = S_IDLE;
            load_single = 1'b0;
            load_mul    = 1'b0;
            mul_start   = 1'b0;
        end
    end

    // Multiplier datapath. After the last step the multiplier register is
    // all zeros, so a stalled final count keeps re-adding nothing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_cnt    <= '0;
            mul_rw     <= 1'b0;
            mul_m2r    <= 1'b0;
            mul_mw     <= 1'b0;
            mul_wreg   <= '0;
            mul_wdata  <= '0;
        end else if (flush) begin
            mul_cnt <= '0;
        end else if (mul_start) begin
            mul_acc    <= '0;
            mul_mcand  <= value1;
            mul_mplier <= op_b;
            mul_cnt    <= '0;
            mul_rw     <= regWriteD;
            mul_m2r    <= memToRegD;
            mul_mw     <= memWriteD;
            mul_wreg   <= write_reg;
            mul_wdata  <= value2;
        end else if (state == S_MUL) begin
            mul_acc    <= mul_sum;
            mul_mcand  <= mul_mcand << 1;
            mul_mplier <= mul_mplier >> 1;
            if (!mul_last)     mul_cnt <= mul_cnt + CNT_W'(1);
            else if (out_free) mul_cnt <= '0;
        end
    end

    // EX/MEM output register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            regWriteE  <= 1'b0;
            memToRegE  <= 1'b0;
            memWriteE  <= 1'b0;
            writeRegE  <= '0;
            aluOutE    <= '0;
            writeDataE <= '0;
`ifdef EXEC_OVF_TRAP_EN
            ovfE       <= 1'b0;
`endif
        end else if (flush) begin
            out_valid <= 1'b0;
            regWriteE <= 1'b0;
            memToRegE <= 1'b0;
            memWriteE <= 1'b0;
`ifdef EXEC_OVF_TRAP_EN
            ovfE      <= 1'b0;
`endif
        end else if (load_single) begin
            out_valid  <= 1'b1;
            regWriteE  <= regWriteD && !alu_ovf;
            memToRegE  <= memToRegD;
            memWriteE  <= memWriteD;
            writeRegE  <= write_reg;
            aluOutE    <= alu_res;
            writeDataE <= value2;
`ifdef EXEC_OVF_TRAP_EN
            ovfE       <= alu_ovf;
`endif
        end else if (load_mul) begin
            out_valid  <= 1'b1;
            regWriteE  <= mul_rw;
            memToRegE  <= mul_m2r;
            memWriteE  <= mul_mw;
            writeRegE  <= mul_wreg;
            aluOutE    <= mul_sum;
            writeDataE <= mul_wdata;
`ifdef EXEC_OVF_TRAP_EN
            ovfE       <= 1'b0;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_exec_stage_pipe.sv
// Self-checking bench for exec_stage_pipe: directed steps for the documented
// scenarios followed by randomized operations against a behavioural model.
module tb_exec_stage_pipe;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned RADDR_W = 5;
    localparam int unsigned CTRL_W  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n, flush, in_valid, in_ready;
    logic               regWriteD, memToRegD, memWriteD, aluSrcD, regDstD;
    logic [CTRL_W-1:0]  aluControlD;
    logic [DATA_W-1:0]  signImmD, value1, value2;
    logic [RADDR_W-1:0] rsD, rtD, rdD;
    logic               out_valid, out_ready;
    logic               regWriteE, memToRegE, memWriteE;
    logic [RADDR_W-1:0] writeRegE;
    logic [DATA_W-1:0]  aluOutE, writeDataE;
`ifdef EXEC_OVF_TRAP_EN
    logic               ovfE;
`endif

    int nchecks = 0;
    int nerrors = 0;

    exec_stage_pipe #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .regWriteD(regWriteD), .memToRegD(memToRegD), .memWriteD(memWriteD),
        .aluControlD(aluControlD), .aluSrcD(aluSrcD), .regDstD(regDstD),
        .signImmD(signImmD), .rsD(rsD), .rtD(rtD), .rdD(rdD),
        .value1(value1), .value2(value2),
        .out_valid(out_valid), .out_ready(out_ready),
        .regWriteE(regWriteE), .memToRegE(memToRegE), .memWriteE(memWriteE),
        .writeRegE(writeRegE), .aluOutE(aluOutE), .writeDataE(writeDataE)
`ifdef EXEC_OVF_TRAP_EN
        , .ovfE(ovfE)
`endif
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, v2, imm;
        logic        alusrc, regdst, rw, m2r, mw;
        logic [4:0]  rs, rt, rd;
    } op_t;

    function automatic op_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] v2,
                               input logic [31:0] imm, input logic alusrc, input logic regdst,
                               input logic [4:0] rt, input logic [4:0] rd);
        op_t o;
        o.op = op; o.a = a; o.v2 = v2; o.imm = imm; o.alusrc = alusrc; o.regdst = regdst;
        o.rw = 1'b1; o.m2r = 1'b0; o.mw = 1'b0; o.rs = 5'd9; o.rt = rt; o.rd = rd;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.op = 4'($urandom_range(0, 15));
        o.a = $urandom; o.v2 = $urandom; o.imm = $urandom;
        o.alusrc = 1'($urandom); o.regdst = 1'($urandom);
        o.rw = 1'($urandom); o.m2r = 1'($urandom); o.mw = 1'($urandom);
        o.rs = 5'($urandom); o.rt = 5'($urandom); o.rd = 5'($urandom);
        return o;
    endfunction

    // Behavioural model: what the MIPS-style EX stage should compute
    function automatic logic [31:0] ref_b(input op_t o);
        return o.alusrc ? o.imm : o.v2;
    endfunction

    function automatic logic [31:0] ref_result(input op_t o);
        logic [31:0] b, r;
        int sh;
        b  = ref_b(o);
        sh = int'(o.imm[10:6]);
        case (o.op)
            4'd0:  r = o.a & b;
            4'd1:  r = o.a | b;
            4'd2:  r = o.a + b;
            4'd3:  r = o.a ^ b;
            4'd4:  r = o.a << sh;
            4'd5:  r = o.a >> sh;
            4'd8:  r = 32'($signed(o.a) >>> sh);
            4'd6:  r = o.a - b;
            4'd7:  r = ($signed(o.a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd12: r = ~(o.a | b);
            4'd15: r = 32'(64'(o.a) * 64'(b));
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic ref_ovf(input op_t o);
        longint sa, sb, s;
        sa = longint'($signed(o.a));
        sb = longint'($signed(ref_b(o)));
        if (o.op == 4'd2)      s = sa + sb;
        else if (o.op == 4'd6) s = sa - sb;
        else                   return 1'b0;
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input op_t o);
        aluControlD = o.op; value1 = o.a; value2 = o.v2; signImmD = o.imm;
        aluSrcD = o.alusrc; regDstD = o.regdst;
        regWriteD = o.rw; memToRegD = o.m2r; memWriteD = o.mw;
        rsD = o.rs; rtD = o.rt; rdD = o.rd;
    endtask

    task automatic check_out(input string tag, input op_t o);
        logic ovf;
        ovf = 1'b0;
`ifdef EXEC_OVF_TRAP_EN
        ovf = ref_ovf(o);
        chk({tag, "/ovf"}, ovfE, ovf);
`endif
        chk({tag, "/valid"}, out_valid, 1'b1);
        chk({tag, "/alu"},   aluOutE, ref_result(o));
        chk({tag, "/wreg"},  writeRegE, o.regdst ? o.rd : o.rt);
        chk({tag, "/wdata"}, writeDataE, o.v2);
        chk({tag, "/ctrl"},  {regWriteE, memToRegE, memWriteE}, {o.rw & ~ovf, o.m2r, o.mw});
    endtask

    // Issue one op into an empty stage, wait for it, hold it, then consume it
    task automatic run_txn(input string tag, input op_t o, input int hold,
                           input bit use_lit, input logic [31:0] lit, input bit chk_busy);
        int lat;
        out_ready = 1'b1;
        drive(o);
        in_valid = 1'b1;
        #1;
        chk({tag, "/in_ready"}, in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 60) begin
            if (chk_busy) chk({tag, "/busy"}, in_ready, 1'b0);
            tick();
            lat++;
        end
        chk({tag, "/latency"}, 64'(lat), (o.op == 4'd15) ? 64'(DATA_W) : 64'd0);
        check_out(tag, o);
        if (use_lit) chk({tag, "/lit"}, aluOutE, lit);
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) tick();
        if (hold > 0) check_out({tag, "/held"}, o);
        out_ready = 1'b1;
        tick();
        chk({tag, "/drained"}, out_valid, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "/valid"}, out_valid, 1'b0);
        chk({tag, "/ctrl"},  {regWriteE, memToRegE, memWriteE}, 3'b000);
        chk({tag, "/wreg"},  writeRegE, 5'd0);
        chk({tag, "/alu"},   aluOutE, 32'd0);
        chk({tag, "/wdata"}, writeDataE, 32'd0);
`ifdef EXEC_OVF_TRAP_EN
        chk({tag, "/ovf"},   ovfE, 1'b0);
`endif
    endtask

    initial begin
        op_t o, o2;
        int seen;

        // Reset with live-looking inputs
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        drive(mk(4'd2, 32'd5, 32'd6, 32'd0, 1'b0, 1'b1, 5'd1, 5'd2));
        tick(); tick();
        chk("reset/in_ready", in_ready, 1'b0);
        check_zero("reset");
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // Directed ALU ops
        run_txn("add_reg",  mk(4'd2, 32'd10, 32'd12, 32'd0,   1'b0, 1'b1, 5'd7, 5'd3), 0, 1'b1, 32'd22, 1'b0);
        run_txn("add_imm",  mk(4'd2, 32'd10, 32'd55, 32'd100, 1'b1, 1'b0, 5'd1, 5'd3), 2, 1'b1, 32'd110, 1'b0);
        run_txn("slt",      mk(4'd7, 32'd10, 32'd12, 32'd0,   1'b0, 1'b1, 5'd1, 5'd4), 0, 1'b1, 32'd1, 1'b0);
        run_txn("sub",      mk(4'd6, 32'd10, 32'd12, 32'd0,   1'b0, 1'b1, 5'd1, 5'd5), 0, 1'b1, 32'hFFFF_FFFE, 1'b0);
        run_txn("sll31",    mk(4'd4, 32'd1, 32'd0, 32'(31 << 6), 1'b0, 1'b1, 5'd1, 5'd6), 0, 1'b1, 32'h8000_0000, 1'b0);
        run_txn("sra4",     mk(4'd8, 32'h8000_0000, 32'd0, 32'(4 << 6), 1'b0, 1'b1, 5'd1, 5'd6), 0, 1'b1, 32'hF800_0000, 1'b0);
        run_txn("srl4",     mk(4'd5, 32'h8000_0000, 32'd0, 32'(4 << 6), 1'b0, 1'b1, 5'd1, 5'd6), 0, 1'b1, 32'h0800_0000, 1'b0);
        run_txn("nor",      mk(4'd12, 32'hF0F0_0000, 32'h0000_0F0F, 32'd0, 1'b0, 1'b1, 5'd1, 5'd6), 0, 1'b1, 32'h0F0F_F0F0, 1'b0);
        run_txn("undef_op", mk(4'd9, 32'h1234, 32'h5678, 32'd0, 1'b0, 1'b1, 5'd1, 5'd6), 0, 1'b1, 32'd0, 1'b0);

        // Multiplier
        run_txn("mul_10x12",  mk(4'd15, 32'd10, 32'd12, 32'd0, 1'b0, 1'b1, 5'd1, 5'd8), 1, 1'b1, 32'd120, 1'b1);
        run_txn("mul_neg1x2", mk(4'd15, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 1'b0, 5'd9, 5'd8), 0, 1'b1, 32'hFFFF_FFFE, 1'b0);

        // Backpressure: second op waits for the first to be consumed
        o  = mk(4'd2, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1, 5'd1, 5'd11);
        o2 = mk(4'd3, 32'hAAAA_0000, 32'h0000_5555, 32'd0, 1'b0, 1'b1, 5'd1, 5'd12);
        out_ready = 1'b0;
        drive(o); in_valid = 1'b1;
        tick();
        drive(o2);
        #1;
        check_out("bp_first", o);
        chk("bp/in_ready_blocked", in_ready, 1'b0);
        tick(); tick();
        check_out("bp_first_held", o);
        chk("bp/in_ready_still_blocked", in_ready, 1'b0);
        out_ready = 1'b1;
        #1;
        chk("bp/in_ready_freed", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        check_out("bp_second", o2);
        tick();
        chk("bp/drained", out_valid, 1'b0);

        // Flush in the middle of a multiply; the op offered alongside is dropped
        drive(mk(4'd15, 32'd7, 32'd9, 32'd0, 1'b0, 1'b1, 5'd1, 5'd13));
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        drive(mk(4'd2, 32'd3, 32'd4, 32'd0, 1'b0, 1'b1, 5'd1, 5'd14));
        flush = 1'b1; in_valid = 1'b1;
        #1;
        chk("flush/in_ready_low", in_ready, 1'b0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush/valid", out_valid, 1'b0);
        chk("flush/in_ready_next", in_ready, 1'b1);
        seen = 0;
        repeat (40) begin tick(); if (out_valid) seen++; end
        chk("flush/no_late_result", 64'(seen), 64'd0);

        // Flush clears a pending output and its control bits
        o = mk(4'd2, 32'd3, 32'd4, 32'd0, 1'b0, 1'b1, 5'd1, 5'd15);
        o.m2r = 1'b1; o.mw = 1'b1;
        out_ready = 1'b0;
        drive(o); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_out("flush_out_pre", o);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_out/valid", out_valid, 1'b0);
        chk("flush_out/ctrl", {regWriteE, memToRegE, memWriteE}, 3'b000);
        out_ready = 1'b1;

        // Reset in the middle of a multiply
        drive(mk(4'd15, 32'd5, 32'd5, 32'd0, 1'b0, 1'b1, 5'd1, 5'd16));
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("rst_mul/in_ready", in_ready, 1'b0);
        tick();
        check_zero("rst_mul");
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin tick(); if (out_valid) seen++; end
        chk("rst_mul/no_late_result", 64'(seen), 64'd0);

`ifdef EXEC_OVF_TRAP_EN
        run_txn("ovf_add", mk(4'd2, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1, 5'd1, 5'd17), 0, 1'b1, 32'h8000_0000, 1'b0);
`endif

        // Randomized operations against the model
        for (int n = 0; n < 200; n++) begin
            o = rand_op();
            run_txn("rand", o, int'($urandom_range(0, 3)), 1'b0, 32'd0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
